multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Moore/Mealy control FSM that sequences the Monociclo datapath as a multicycle core: instruction fetch, decode, execute, data memory access and writeback.
- Selects the immediate format consumed by the sign-extension unit, the ALU source and operation, and the register-file and PC writes.
- Handles req/ack handshakes to instruction and data memory, with a timeout per handshake.
- Supports opcodes 0110011 (R), 0010011 (I-ALU), 0000011 (lw), 0100011 (sw) and 1100011 (beq/bne).

Parameters:
WORD, 32, instruction width
OPCODE, 7, opcode field width
TIMEOUT, 16, max cycles a memory request waits for ack (>=2)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous, active-high reset
inst_i  in  WORD  instruction held in IR
imem_ack_i  in  1  instruction memory ack; IR data valid this cycle
dmem_ack_i  in  1  data memory ack
alu_zero_i  in  1  ALU result == 0
imem_req_o  out  1  instruction fetch request
ir_we_o  out  1  IR load enable
pc_we_o  out  1  PC write enable
pc_sel_o  out  1  0 = PC+4, 1 = branch target (PC+imm)
imm_sel_o  out  2  00 I-format, 01 S-format, 10 B-format, 11 none
alu_src_o  out  1  0 = rs2, 1 = sign-extended immediate
alu_op_o  out  2  00 add, 01 sub (compare), 10 funct3/funct7-decoded
dmem_req_o  out  1  data memory request
dmem_we_o  out  1  data memory write (valid only with dmem_req_o)
rf_we_o  out  1  register-file write enable
wb_sel_o  out  1  0 = ALU result, 1 = memory data
illegal_o  out  1  one-cycle pulse on unsupported instruction
bus_err_o  out  1  one-cycle pulse on memory timeout
state_o  out  3  current state (debug)

Behaviour:
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5. Codes 6-7 are unreachable and map to FETCH on the next edge.
- Reset: on a clock edge with rst_i=1, state goes to FETCH, the wait counter clears to 0 and the class register clears. While rst_i=1 every output is forced to 0, including state_o. Reset mid-handshake abandons it; requests drop in the same cycle rst_i rises.
- FETCH: imem_req_o=1 until imem_ack_i. In the ack cycle ir_we_o=1 and the next state is DECODE.
- DECODE (1 cycle): classify inst_i[6:0] into a class register.
  - Branch with funct3 not in {000,001} is illegal.
  - Any other opcode not listed in the Overview is illegal.
  - Illegal: illegal_o=1, pc_we_o=1, pc_sel_o=0 (skip the instruction), next state FETCH.
  - Otherwise next state EXEC.
- EXEC (1 cycle):
  - R: imm_sel=11, alu_src=0, alu_op=10, next WB.
  - I-ALU: imm_sel=00, alu_src=1, alu_op=10, next WB.
  - lw: imm_sel=00, alu_src=1, alu_op=00, next MEM.
  - sw: imm_sel=01, alu_src=1, alu_op=00, next MEM.
  - Branch: imm_sel=10, alu_src=0, alu_op=01, pc_we_o=1, pc_sel_o = alu_zero_i XOR inst_i[12], next FETCH.
- imm_sel, alu_src and alu_op stay stable from EXEC through MEM and WB for the same instruction.
- MEM: dmem_req_o=1 until dmem_ack_i, with dmem_we_o=1 for sw.
  - On ack, sw: pc_we_o=1, pc_sel_o=0, next FETCH.
  - On ack, lw: next WB.
- WB (1 cycle): rf_we_o=1, wb_sel_o=1 for lw and 0 otherwise, pc_we_o=1, pc_sel_o=0, next FETCH.
- Timeout: the wait counter increments each FETCH/MEM cycle without ack and clears on ack or on state change. When the counter reaches TIMEOUT-1 with no ack, the next state is ERR and the request is dropped.
- ERR (1 cycle): bus_err_o=1, all requests 0.
  - If entered from MEM: pc_we_o=1, pc_sel_o=0 (skip the instruction, no rf write).
  - If entered from FETCH: no PC write (retry the same PC).
  - Next state FETCH.
- An ack arriving in the same cycle as the counter reaching TIMEOUT-1 counts as success; ack wins.
- Acks outside FETCH/MEM are ignored.
- At most one of imem_req_o and dmem_req_o is high in any cycle.
- Latency with zero-wait acks: R/I 4 cycles, lw 5, sw 4, branch 3, illegal 2.

Test Plan:
- Reset then addi x1,x0,5 (0x00500093), imem ack same cycle -> state_o 0,1,2,4; imm_sel=00, alu_src=1 in EXEC; rf_we_o=1 and pc_we_o=1 only in WB; 4 cycles total.
- lw x2,4(x1) (0x0040A103), dmem_ack after 3 wait cycles -> dmem_req_o high 4 cycles with dmem_we_o=0; WB has wb_sel_o=1, rf_we_o=1; 8 cycles total.
- sw x2,8(x1) (0x0020A423) -> imm_sel=01; dmem_we_o=1 with req; rf_we_o never 1; pc_we_o in the ack cycle; back to FETCH.
- beq x0,x0,8 (0x00000463) with alu_zero_i=1 -> EXEC: pc_we_o=1, pc_sel_o=1. bne (0x00001463) with alu_zero_i=1 -> pc_sel_o=0.
- inst 0x0000007F, then branch with funct3=010 -> illegal_o pulse in DECODE, pc_we_o=1, pc_sel_o=0, no rf_we_o, no EXEC entry.
- TIMEOUT=16, imem never acks -> req high 16 cycles, ERR with bus_err_o=1 and pc_we_o=0, then FETCH re-requests. rst_i asserted mid-MEM -> dmem_req_o=0 in that cycle, state_o=0 after release.

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl_if
//  Description : Bundles every signal exchanged between the multicycle control
//                FSM and its surroundings (IR, instruction/data memory
//                handshakes, ALU flag and datapath controls).
//                master : controller side (drives requests and controls)
//                slave  : datapath / memory side (drives IR, acks, ALU flag)
//  Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_ctrl_if #(
  parameter int WORD = 32
);
  logic [WORD-1:0] inst_i;
  logic            imem_ack_i;
  logic            dmem_ack_i;
  logic            alu_zero_i;
  logic            imem_req_o;
  logic            ir_we_o;
  logic            pc_we_o;
  logic            pc_sel_o;
  logic [1:0]      imm_sel_o;
  logic            alu_src_o;
  logic [1:0]      alu_op_o;
  logic            dmem_req_o;
  logic            dmem_we_o;
  logic            rf_we_o;
  logic            wb_sel_o;
  logic            illegal_o;
  logic            bus_err_o;
  logic [2:0]      state_o;

  modport master (
    input  inst_i, imem_ack_i, dmem_ack_i, alu_zero_i,
    output imem_req_o, ir_we_o, pc_we_o, pc_sel_o, imm_sel_o, alu_src_o,
           alu_op_o, dmem_req_o, dmem_we_o, rf_we_o, wb_sel_o, illegal_o,
           bus_err_o, state_o
  );

  modport slave (
    output inst_i, imem_ack_i, dmem_ack_i, alu_zero_i,
    input  imem_req_o, ir_we_o, pc_we_o, pc_sel_o, imm_sel_o, alu_src_o,
           alu_op_o, dmem_req_o, dmem_we_o, rf_we_o, wb_sel_o, illegal_o,
           bus_err_o, state_o
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_ctrl
//  Description : Control FSM sequencing a single-cycle datapath as a
//                multicycle core: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
//                Handles imem/dmem req/ack handshakes with a per-handshake
//                timeout and flags unsupported instructions.
//  Ports       : clk_i  - clock (rising edge)
//                rst_i  - synchronous active-high reset, forces outputs to 0
//                bus    - multicycle_ctrl_if master modport (IR, acks,
//                         ALU zero flag in; memory requests, datapath
//                         controls, error pulses and debug state out)
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl #(
  parameter int WORD    = 32,
  parameter int OPCODE  = 7,
  parameter int TIMEOUT = 16
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  multicycle_ctrl_if.master  bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [OPCODE-1:0] OP_R  = OPCODE'(7'b0110011);
  localparam logic [OPCODE-1:0] OP_I  = OPCODE'(7'b0010011);
  localparam logic [OPCODE-1:0] OP_LW = OPCODE'(7'b0000011);
  localparam logic [OPCODE-1:0] OP_SW = OPCODE'(7'b0100011);
  localparam logic [OPCODE-1:0] OP_BR = OPCODE'(7'b1100011);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    ERR    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_LW  = 3'd2,
    CLS_SW  = 3'd3,
    CLS_BR  = 3'd4,
    CLS_ILL = 3'd5
  } cls_e;

  state_e           state_q, state_d;
  cls_e             cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_mem_q, err_mem_d;   // ERR entered from MEM (skip instr)

  // Raw (pre-reset-gating) outputs
  logic       imem_req, ir_we, pc_we, pc_sel, alu_src;
  logic       dmem_req, dmem_we, rf_we, wb_sel, illegal, bus_err;
  logic [1:0] imm_sel, alu_op;
  cls_e       cls_dec;
  logic       timed_out;

  // Bits of the instruction the controller does not look at
  logic unused_inst;
  assign unused_inst = ^{bus.inst_i[WORD-1:15], bus.inst_i[11:OPCODE]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= FETCH;
      cls_q     <= CLS_R;
      cnt_q     <= '0;
      err_mem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      cnt_q     <= cnt_d;
      err_mem_q <= err_mem_d;
    end
  end

  // Opcode classification, consumed only in DECODE
  always_comb begin
    cls_dec = CLS_ILL;
    unique case (bus.inst_i[OPCODE-1:0])
      OP_R:    cls_dec = CLS_R;
      OP_I:    cls_dec = CLS_I;
      OP_LW:   cls_dec = CLS_LW;
      OP_SW:   cls_dec = CLS_SW;
      OP_BR:   cls_dec = (bus.inst_i[14:13] == 2'b00) ? CLS_BR : CLS_ILL;
      default: cls_dec = CLS_ILL;
    endcase
  end

  assign timed_out = (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    cnt_d     = '0;          // cleared on ack and on every state change
    err_mem_d = err_mem_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 1'b0;
    imm_sel   = 2'b11;
    alu_src   = 1'b0;
    alu_op    = 2'b00;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;

    // ALU/immediate controls held from EXEC through MEM and WB
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      unique case (cls_q)
        CLS_R:   begin imm_sel = 2'b11; alu_src = 1'b0; alu_op = 2'b10; end
        CLS_I:   begin imm_sel = 2'b00; alu_src = 1'b1; alu_op = 2'b10; end
        CLS_LW:  begin imm_sel = 2'b00; alu_src = 1'b1; alu_op = 2'b00; end
        CLS_SW:  begin imm_sel = 2'b01; alu_src = 1'b1; alu_op = 2'b00; end
        CLS_BR:  begin imm_sel = 2'b10; alu_src = 1'b0; alu_op = 2'b01; end
        default: begin imm_sel = 2'b11; alu_src = 1'b0; alu_op = 2'b00; end
      endcase
    end

    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack_i) begin            // ack wins over timeout
          ir_we   = 1'b1;
          state_d = DECODE;
        end else if (timed_out) begin
          state_d   = ERR;
          err_mem_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DECODE: begin
        cls_d = cls_dec;
        if (cls_dec == CLS_ILL) begin
          illegal = 1'b1;
          pc_we   = 1'b1;
          state_d = FETCH;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        unique case (cls_q)
          CLS_R, CLS_I:   state_d = WB;
          CLS_LW, CLS_SW: state_d = MEM;
          CLS_BR: begin
            // inst[12] distinguishes bne from beq and inverts the condition
            pc_we   = 1'b1;
            pc_sel  = bus.alu_zero_i ^ bus.inst_i[12];
            state_d = FETCH;
          end
          default:        state_d = FETCH;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (cls_q == CLS_SW);
        if (bus.dmem_ack_i) begin
          if (cls_q == CLS_SW) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end else if (timed_out) begin
          state_d   = ERR;
          err_mem_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WB: begin
        rf_we   = 1'b1;
        wb_sel  = (cls_q == CLS_LW);
        pc_we   = 1'b1;
        state_d = FETCH;
      end
      ERR: begin
        bus_err = 1'b1;
        pc_we   = err_mem_q;     // fetch errors retry the same PC
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset forces every output low combinationally, so requests drop in the
  // same cycle rst_i rises.
  assign bus.imem_req_o = imem_req & ~rst_i;
  assign bus.ir_we_o    = ir_we    & ~rst_i;
  assign bus.pc_we_o    = pc_we    & ~rst_i;
  assign bus.pc_sel_o   = pc_sel   & ~rst_i;
  assign bus.imm_sel_o  = imm_sel  & {2{~rst_i}};
  assign bus.alu_src_o  = alu_src  & ~rst_i;
  assign bus.alu_op_o   = alu_op   & {2{~rst_i}};
  assign bus.dmem_req_o = dmem_req & ~rst_i;
  assign bus.dmem_we_o  = dmem_we  & ~rst_i;
  assign bus.rf_we_o    = rf_we    & ~rst_i;
  assign bus.wb_sel_o   = wb_sel   & ~rst_i;
  assign bus.illegal_o  = illegal  & ~rst_i;
  assign bus.bus_err_o  = bus_err  & ~rst_i;
  assign bus.state_o    = rst_i ? 3'd0 : state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_ctrl
//  Description : Self-checking bench for multicycle_ctrl. Each cycle drives
//                the IR/ack/zero inputs, queues the expected output snapshot
//                and compares it mid-cycle against the controller outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int TIMEOUT = 16;
  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.WORD(32)) bus ();

  multicycle_ctrl #(.WORD(32), .OPCODE(7), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       pc_we;
    logic       pc_sel;
    logic [1:0] imm_sel;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       dmem_req;
    logic       dmem_we;
    logic       rf_we;
    logic       wb_sel;
    logic       illegal;
    logic       bus_err;
    logic [2:0] state;
  } out_t;

  typedef struct packed {
    out_t v;   // expected value
    out_t m;   // care mask
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check_val(input string tag, input logic [17:0] act, input logic [17:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic out_t act_vec();
    out_t a;
    a.imem_req = bus.imem_req_o;
    a.ir_we    = bus.ir_we_o;
    a.pc_we    = bus.pc_we_o;
    a.pc_sel   = bus.pc_sel_o;
    a.imm_sel  = bus.imm_sel_o;
    a.alu_src  = bus.alu_src_o;
    a.alu_op   = bus.alu_op_o;
    a.dmem_req = bus.dmem_req_o;
    a.dmem_we  = bus.dmem_we_o;
    a.rf_we    = bus.rf_we_o;
    a.wb_sel   = bus.wb_sel_o;
    a.illegal  = bus.illegal_o;
    a.bus_err  = bus.bus_err_o;
    a.state    = bus.state_o;
    return a;
  endfunction

  // ---------------- expected-snapshot builders ----------------
  function automatic exp_t e_rst();
    exp_t e;
    e.v = '0;
    e.m = '1;
    return e;
  endfunction

  // All outputs 0 except state; ALU fields, pc_sel, dmem_we, wb_sel are
  // don't-care until a builder makes them meaningful.
  function automatic exp_t e_base(input logic [2:0] st);
    exp_t e;
    e.v = '0;
    e.v.state = st;
    e.m = '1;
    e.m.imm_sel = 2'b00;
    e.m.alu_src = 1'b0;
    e.m.alu_op  = 2'b00;
    e.m.pc_sel  = 1'b0;
    e.m.dmem_we = 1'b0;
    e.m.wb_sel  = 1'b0;
    return e;
  endfunction

  function automatic exp_t e_ctl(input exp_t ei, input int cls);
    exp_t e = ei;
    e.m.imm_sel = 2'b11;
    e.m.alu_src = 1'b1;
    e.m.alu_op  = 2'b11;
    case (cls)
      C_R:     begin e.v.imm_sel = 2'b11; e.v.alu_src = 1'b0; e.v.alu_op = 2'b10; end
      C_I:     begin e.v.imm_sel = 2'b00; e.v.alu_src = 1'b1; e.v.alu_op = 2'b10; end
      C_LW:    begin e.v.imm_sel = 2'b00; e.v.alu_src = 1'b1; e.v.alu_op = 2'b00; end
      C_SW:    begin e.v.imm_sel = 2'b01; e.v.alu_src = 1'b1; e.v.alu_op = 2'b00; end
      default: begin e.v.imm_sel = 2'b10; e.v.alu_src = 1'b0; e.v.alu_op = 2'b01; end
    endcase
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic ack);
    exp_t e = e_base(3'd0);
    e.v.imem_req = 1'b1;
    e.v.ir_we    = ack;
    return e;
  endfunction

  function automatic exp_t e_decode(input logic ill);
    exp_t e = e_base(3'd1);
    e.v.illegal = ill;
    e.v.pc_we   = ill;
    e.m.pc_sel  = ill;
    return e;
  endfunction

  function automatic exp_t e_exec(input int cls, input logic sel);
    exp_t e = e_ctl(e_base(3'd2), cls);
    if (cls == C_BR) begin
      e.v.pc_we  = 1'b1;
      e.v.pc_sel = sel;
      e.m.pc_sel = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t e_mem(input int cls, input logic ack);
    exp_t e = e_ctl(e_base(3'd3), cls);
    e.v.dmem_req = 1'b1;
    e.v.dmem_we  = (cls == C_SW);
    e.m.dmem_we  = 1'b1;
    e.v.pc_we    = ack && (cls == C_SW);
    e.m.pc_sel   = e.v.pc_we;
    return e;
  endfunction

  function automatic exp_t e_wb(input int cls);
    exp_t e = e_ctl(e_base(3'd4), cls);
    e.v.rf_we  = 1'b1;
    e.v.wb_sel = (cls == C_LW);
    e.m.wb_sel = 1'b1;
    e.v.pc_we  = 1'b1;
    e.m.pc_sel = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_err(input logic from_mem);
    exp_t e = e_base(3'd5);
    e.v.bus_err = 1'b1;
    e.v.pc_we   = from_mem;
    e.m.pc_sel  = from_mem;
    return e;
  endfunction

  // One clock cycle: drive inputs, queue expectation, compare mid-cycle.
  task automatic step(input string tag, input logic [31:0] inst, input logic iack,
                      input logic dack, input logic zero, input logic rst_v,
                      input exp_t e);
    exp_t x;
    out_t a;
    bus.inst_i     = inst;
    bus.imem_ack_i = iack;
    bus.dmem_ack_i = dack;
    bus.alu_zero_i = zero;
    rst            = rst_v;
    sb_q.push_back(e);
    @(negedge clk);
    x = sb_q.pop_front();
    a = act_vec();
    check_val(tag, a & x.m, x.v & x.m);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] LW   = 32'h0040_A103;
  localparam logic [31:0] SW   = 32'h0020_A423;
  localparam logic [31:0] BEQ  = 32'h0000_0463;
  localparam logic [31:0] BNE  = 32'h0000_1463;
  localparam logic [31:0] ADD  = 32'h0020_81B3;
  localparam logic [31:0] BAD7 = 32'h0000_007F;
  localparam logic [31:0] BR2  = 32'h0000_2463;

  initial begin
    rst            = 1'b1;
    bus.inst_i     = '0;
    bus.imem_ack_i = 1'b0;
    bus.dmem_ack_i = 1'b0;
    bus.alu_zero_i = 1'b0;

    step("reset0", 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, e_rst());
    step("reset1", 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, e_rst());

    // addi: 4 cycles
    step("addi_fetch",  ADDI, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
    step("addi_decode", ADDI, 1'b1, 1'b1, 1'b0, 1'b0, e_decode(1'b0)); // stray acks ignored
    step("addi_exec",   ADDI, 1'b0, 1'b0, 1'b0, 1'b0, e_exec(C_I, 1'b0));
    step("addi_wb",     ADDI, 1'b0, 1'b0, 1'b0, 1'b0, e_wb(C_I));

    // lw with 3 wait cycles: 8 cycles
    step("lw_fetch",  LW, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
    step("lw_decode", LW, 1'b0, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
    step("lw_exec",   LW, 1'b0, 1'b0, 1'b0, 1'b0, e_exec(C_LW, 1'b0));
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", LW, 1'b0, 1'b0, 1'b0, 1'b0, e_mem(C_LW, 1'b0));
    step("lw_mem_ack", LW, 1'b0, 1'b1, 1'b0, 1'b0, e_mem(C_LW, 1'b1));
    step("lw_wb",      LW, 1'b0, 1'b0, 1'b0, 1'b0, e_wb(C_LW));

    // sw
    step("sw_fetch",   SW, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
    step("sw_decode",  SW, 1'b0, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
    step("sw_exec",    SW, 1'b0, 1'b1, 1'b0, 1'b0, e_exec(C_SW, 1'b0));
    step("sw_mem_ack", SW, 1'b0, 1'b1, 1'b0, 1'b0, e_mem(C_SW, 1'b1));

    // branches
    step("beq_fetch",  BEQ, 1'b1, 1'b0, 1'b1, 1'b0, e_fetch(1'b1));
    step("beq_decode", BEQ, 1'b0, 1'b0, 1'b1, 1'b0, e_decode(1'b0));
    step("beq_exec_z", BEQ, 1'b0, 1'b0, 1'b1, 1'b0, e_exec(C_BR, 1'b1));
    step("bne_fetch",  BNE, 1'b1, 1'b0, 1'b1, 1'b0, e_fetch(1'b1));
    step("bne_decode", BNE, 1'b0, 1'b0, 1'b1, 1'b0, e_decode(1'b0));
    step("bne_exec_z", BNE, 1'b0, 1'b0, 1'b1, 1'b0, e_exec(C_BR, 1'b0));
    step("beq_fetch2", BEQ, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
    step("beq_decode2",BEQ, 1'b0, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
    step("beq_exec_nz",BEQ, 1'b0, 1'b0, 1'b0, 1'b0, e_exec(C_BR, 1'b0));

    // illegal instructions
    step("ill7_fetch",  BAD7, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
    step("ill7_decode", BAD7, 1'b0, 1'b0, 1'b0, 1'b0, e_decode(1'b1));
    step("illbr_fetch", BR2,  1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
    step("illbr_decode",BR2,  1'b0, 1'b0, 1'b0, 1'b0, e_decode(1'b1));

    // fetch timeout: req high TIMEOUT cycles, ERR without PC write, retry
    for (int i = 0; i < TIMEOUT; i++)
      step("ito_wait", ADD, 1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    step("ito_err",    ADD, 1'b0, 1'b0, 1'b0, 1'b0, e_err(1'b0));
    step("add_fetch",  ADD, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
    step("add_decode", ADD, 1'b0, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
    step("add_exec",   ADD, 1'b0, 1'b0, 1'b0, 1'b0, e_exec(C_R, 1'b0));
    step("add_wb",     ADD, 1'b0, 1'b0, 1'b0, 1'b0, e_wb(C_R));

    // ack on the last allowed cycle still succeeds
    for (int i = 0; i < TIMEOUT - 1; i++)
      step("iedge_wait", ADDI, 1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    step("iedge_ack",    ADDI, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
    step("iedge_decode", ADDI, 1'b0, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
    step("iedge_exec",   ADDI, 1'b0, 1'b0, 1'b0, 1'b0, e_exec(C_I, 1'b0));
    step("iedge_wb",     ADDI, 1'b0, 1'b0, 1'b0, 1'b0, e_wb(C_I));

    // data timeout: ERR skips the instruction
    step("dto_fetch",  LW, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
    step("dto_decode", LW, 1'b0, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
    step("dto_exec",   LW, 1'b0, 1'b0, 1'b0, 1'b0, e_exec(C_LW, 1'b0));
    for (int i = 0; i < TIMEOUT; i++)
      step("dto_wait", LW, 1'b0, 1'b0, 1'b0, 1'b0, e_mem(C_LW, 1'b0));
    step("dto_err",    LW, 1'b0, 1'b0, 1'b0, 1'b0, e_err(1'b1));

    // reset mid-MEM abandons the handshake
    step("rm_fetch",  SW, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));
    step("rm_decode", SW, 1'b0, 1'b0, 1'b0, 1'b0, e_decode(1'b0));
    step("rm_exec",   SW, 1'b0, 1'b0, 1'b0, 1'b0, e_exec(C_SW, 1'b0));
    step("rm_mem",    SW, 1'b0, 1'b0, 1'b0, 1'b0, e_mem(C_SW, 1'b0));
    step("rm_rst",    SW, 1'b0, 1'b0, 1'b0, 1'b1, e_rst());
    // counter must be cleared: full TIMEOUT wait window again after reset
    for (int i = 0; i < TIMEOUT; i++)
      step("rm_refetch", ADDI, 1'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));
    step("rm_err",    ADDI, 1'b0, 1'b0, 1'b0, 1'b0, e_err(1'b0));
    step("rm_after",  ADDI, 1'b1, 1'b0, 1'b0, 1'b0, e_fetch(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
